instr_fetch_queue: RTL and testbench

Parametrised instruction register successor. It holds a DEPTH-entry circular queue of fetched {pc, instr} pairs between instruction memory and decode. It uses valid/ready handshakes on both sides and a synchronous flush for branch/jump redirect. The head entry drives the decode-side outputs directly from registers.

---
 rtl/instr_fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue_ctrl.sv | 54 +++++
 rtl/instr_fetch_queue.sv | 69 ++++++
 tb/tb_instr_fetch_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage types and encodings used by fetch, the fetch queue and decode.
package instr_fetch_queue_pkg;

  localparam int FETCH_DATA_W = 32;
  localparam int FETCH_ADDR_W = 32;

  // Canonical NOP loaded into empty slots so a stale head never decodes as garbage.
  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Pointer, occupancy and handshake control for the fetch queue; storage lives in the parent.
module fetch_queue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic                         out_ready,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic                         push,
  output logic                         pop,
  output logic [$clog2(DEPTH)-1:0]     wr_ptr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic full;
  logic empty;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // Flush cancels any handshake in the same cycle, including the storage write.
  assign push = in_valid & in_ready & !flush;
  assign pop  = out_valid & out_ready & !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular queue of fetched {pc, instr} pairs between instruction memory and decode.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int                DATA_W      = FETCH_DATA_W,
  parameter int                ADDR_W      = FETCH_ADDR_W,
  parameter int                DEPTH       = 4,
  parameter logic [DATA_W-1:0] RESET_INSTR = DATA_W'(NOP_INSTR),
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic [ADDR_W-1:0]          in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t             slots [DEPTH];
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  fetch_queue_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .count     (count),
    .rd_ptr    (rd_ptr)
  );

  // Flush leaves storage intact; only reset restores the NOP image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '{pc: RESET_PC, instr: RESET_INSTR};
      end
    end else if (push) begin
      slots[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

  assign out_instr = slots[rd_ptr].instr;
  assign out_pc    = slots[rd_ptr].pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue with DEPTH=4 and non-zero reset values.
module tb_instr_fetch_queue;

  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] R_INSTR = 32'h0000_0013;
  localparam logic [31:0] R_PC    = 32'h8000_0000;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .RESET_INSTR (R_INSTR),
    .RESET_PC    (R_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic ordy);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, ".count"},     32'(count),     32'd0);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 32'hx, 32'hx, 1'b0);

    // 1: asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    checkEmpty("rst");
    checkOutput("rst.out_instr", out_instr, R_INSTR);
    checkOutput("rst.out_pc",    out_pc,    R_PC);
    #12 rst = 1'b0;
    tick();
    checkEmpty("post_rst");
    checkOutput("post_rst.out_instr", out_instr, R_INSTR);

    // 2: fill, overflow refusal, hold, drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), 32'(4 * i), 1'b0);
      tick();
      checkOutput("fill.count", 32'(count), 32'(i + 1));
    end
    checkOutput("full.in_ready", 32'(in_ready), 32'd0);
    checkOutput("full.head", out_instr, 32'hA0);
    applyStimulus(1'b1, 32'hA4, 32'h10, 1'b0);
    tick();
    checkOutput("overflow.count", 32'(count), 32'd4);
    applyStimulus(1'b0, 32'hx, 32'hx, 1'b0);
    tick();
    checkOutput("hold.count", 32'(count), 32'd4);
    checkOutput("hold.head_pc", out_pc, 32'h0);
    applyStimulus(1'b0, 32'hx, 32'hx, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain.instr", out_instr, 32'hA0 + 32'(i));
      checkOutput("drain.pc",    out_pc,    32'(4 * i));
      checkOutput("drain.valid", 32'(out_valid), 32'd1);
      tick();
    end
    checkEmpty("drained");

    // 3: push+pop while full only pops; push lands next cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hB0 + 32'(i), 32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    checkOutput("full2.count", 32'(count), 32'd4);
    applyStimulus(1'b1, 32'hC0, 32'h200, 1'b1);
    tick();
    checkOutput("fullpp.count", 32'(count), 32'd3);
    checkOutput("fullpp.head",  out_instr,  32'hB1);
    applyStimulus(1'b1, 32'hC0, 32'h200, 1'b0);
    tick();
    checkOutput("refill.count", 32'(count), 32'd4);
    applyStimulus(1'b0, 32'hx, 32'hx, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain2.instr", out_instr, (i < 3) ? 32'hB1 + 32'(i) : 32'hC0);
      checkOutput("drain2.pc",    out_pc,    (i < 3) ? 32'h104 + 32'(4 * i) : 32'h200);
      tick();
    end
    checkEmpty("drained2");

    // 4: streaming across pointer wrap, one-cycle latency
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'hD0 + 32'(i), 32'h300 + 32'(4 * i), 1'b1);
      tick();
      checkOutput("stream.count", 32'(count), 32'd1);
      checkOutput("stream.valid", 32'(out_valid), 32'd1);
      checkOutput("stream.instr", out_instr, 32'hD0 + 32'(i));
      checkOutput("stream.pc",    out_pc,    32'h300 + 32'(4 * i));
    end
    applyStimulus(1'b0, 32'hx, 32'hx, 1'b1);
    tick();
    checkEmpty("stream_end");

    // 5: flush beats concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hE0 + 32'(i), 32'h400 + 32'(4 * i), 1'b0);
      tick();
    end
    checkOutput("preflush.count", 32'(count), 32'd3);
    applyStimulus(1'b1, 32'hF0, 32'h4F0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkEmpty("flush");
    applyStimulus(1'b1, 32'h60, 32'h500, 1'b0);
    tick();
    checkOutput("postflush.count", 32'(count), 32'd1);
    checkOutput("postflush.valid", 32'(out_valid), 32'd1);
    checkOutput("postflush.instr", out_instr, 32'h60);
    checkOutput("postflush.pc",    out_pc,    32'h500);
    applyStimulus(1'b0, 32'hx, 32'hx, 1'b1);
    tick();
    checkEmpty("postflush_pop");

    // 6: asynchronous reset with entries queued
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h70 + 32'(i), 32'h600 + 32'(4 * i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'hx, 32'hx, 1'b0);
    checkOutput("prerst.count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    checkEmpty("async_rst");
    checkOutput("async_rst.out_pc",    out_pc,    R_PC);
    checkOutput("async_rst.out_instr", out_instr, R_INSTR);
    #3 rst = 1'b0;
    tick();
    checkEmpty("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
